// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, FSM states, mux encodings.
package cpu_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_IDLE, S_F_REQ, S_F_WAIT, S_DEC, S_EXE, S_M_REQ, S_M_WAIT, S_WB, S_TRAP
  } state_t;

  // BUS address select
  localparam logic [1:0] ADDR_ALU  = 2'd0;
  localparam logic [1:0] ADDR_PC   = 2'd3;
  // BUS write-data select
  localparam logic [2:0] DATA_ALU  = 3'd0;
  localparam logic [2:0] DATA_REG1 = 3'd2;
  // PC load source
  localparam logic [1:0] PCS_ALU   = 2'd0;
  // ALU num1 select
  localparam logic [1:0] ALU_PC    = 2'd0;
  localparam logic [1:0] ALU_IM    = 2'd1;
  localparam logic [1:0] ALU_REG0  = 2'd2;
  // Register writeback source
  localparam logic [2:0] REG_ALU   = 3'd0;
  localparam logic [2:0] REG_PC    = 3'd3;
  localparam logic [2:0] REG_IM    = 3'd4;
  localparam logic [2:0] REG_LOAD  = 3'd5;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_JAL) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_if.sv
// Handshake bundle between the sequencer (master) and BUS_controller_top (slave).
interface cpu_ctrl_seq_if;
  logic        start_transaction;
  logic        mode_BUS;
  logic [1:0]  addr_CS;
  logic [2:0]  data_CS;
  logic        rdata_valid;
  logic        write_done;
  logic [31:0] rdata;

  modport master (output start_transaction, mode_BUS, addr_CS, data_CS,
                  input  rdata_valid, write_done, rdata);
  modport slave  (input  start_transaction, mode_BUS, addr_CS, data_CS,
                  output rdata_valid, write_done, rdata);
endinterface

// File: rtl/cpu_imm_gen.sv
// Combinational immediate decoder: I/S/J/U formats selected by opcode.
module cpu_imm_gen
  import cpu_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [31:0] o_im
);

  // Pick the immediate layout that matches the opcode; others give 0
  always_comb begin
    o_im = 32'd0;
    case (i_ir[6:0])
      OP_ADDI, OP_LW: o_im = {{20{i_ir[31]}}, i_ir[31:20]};
      OP_SW:          o_im = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
      OP_JAL:         o_im = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
      OP_LUI:         o_im = {i_ir[31:12], 12'd0};
      default:        o_im = 32'd0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for an RV32I subset.
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [7:0]  BUS_TIMEOUT = 8'd255
)(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           RUN,
  cpu_ctrl_seq_if.master bus,
  output logic           PC_EN,
  output logic           PC_mode,
  output logic [1:0]     PC_CS,
  output logic [31:0]    pc_init,
  output logic           ALU_mode,
  output logic [1:0]     ALU_CS,
  output logic [4:0]     reg_raddr1,
  output logic [4:0]     reg_raddr2,
  output logic [4:0]     reg_waddr,
  output logic           reg_wen,
  output logic [2:0]     reg_CS,
  output logic [31:0]    IR,
  output logic [31:0]    IM,
  output logic [31:0]    load_data,
  output logic           halted,
  output logic           trap
);

  state_t      r_state, w_nxt;
  logic [31:0] r_ir, r_load_data;
  logic [7:0]  r_cnt;

  logic [6:0]  w_op;
  logic        w_is_r, w_is_lw, w_is_sw, w_is_jal, w_is_lui, w_rd_nz, w_span, w_mem;
  logic        w_start, w_mode_bus, w_pc_en, w_pc_mode, w_alu_mode, w_reg_wen;
  logic [1:0]  w_addr_cs, w_alu_cs;
  logic [2:0]  w_data_cs, w_reg_cs;

  assign w_op     = r_ir[6:0];
  assign w_is_r   = (w_op == OP_R);
  assign w_is_lw  = (w_op == OP_LW);
  assign w_is_sw  = (w_op == OP_SW);
  assign w_is_jal = (w_op == OP_JAL);
  assign w_is_lui = (w_op == OP_LUI);
  assign w_rd_nz  = (r_ir[11:7] != 5'd0);
  assign w_span   = (r_state == S_EXE) || (r_state == S_M_REQ) ||
                    (r_state == S_M_WAIT) || (r_state == S_WB);
  assign w_mem    = (r_state == S_M_REQ) || (r_state == S_M_WAIT);

  cpu_imm_gen u_imm (.i_ir(r_ir), .o_im(IM));

  // State register, instruction/load capture and bus wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ir        <= 32'd0;
      r_load_data <= 32'd0;
      r_cnt       <= 8'd0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_F_WAIT && bus.rdata_valid) r_ir <= bus.rdata;
      if (r_state == S_M_WAIT && w_is_lw && bus.rdata_valid) r_load_data <= bus.rdata;
      if (r_state == S_F_REQ || r_state == S_M_REQ)
        r_cnt <= 8'd0;
      else if (r_state == S_F_WAIT || r_state == S_M_WAIT)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  // Next state, strobes and mux selects
  always_comb begin
    w_nxt      = r_state;
    w_start    = 1'b0;
    w_mode_bus = 1'b0;
    w_addr_cs  = ADDR_ALU;
    w_data_cs  = DATA_ALU;
    w_pc_en    = 1'b0;
    w_pc_mode  = 1'b0;
    w_alu_mode = 1'b0;
    w_alu_cs   = ALU_PC;
    w_reg_wen  = 1'b0;
    w_reg_cs   = REG_ALU;
    case (r_state)
      S_IDLE:   if (RUN) w_nxt = S_F_REQ;
      S_F_REQ: begin
        w_start   = 1'b1;
        w_addr_cs = ADDR_PC;
        w_nxt     = S_F_WAIT;
      end
      S_F_WAIT: begin
        if (bus.rdata_valid)            w_nxt = S_DEC;
        else if (r_cnt == BUS_TIMEOUT)  w_nxt = S_TRAP;
      end
      S_DEC:    w_nxt = op_legal(w_op) ? S_EXE : S_TRAP;
      S_EXE: begin
        if (w_is_jal) begin
          w_reg_wen = w_rd_nz;
          w_pc_en   = 1'b1;
          w_pc_mode = 1'b1;
          w_nxt     = RUN ? S_F_REQ : S_IDLE;
        end else if (w_is_lw || w_is_sw) begin
          w_nxt = S_M_REQ;
        end else begin
          w_nxt = S_WB;
        end
      end
      S_M_REQ: begin
        w_start = 1'b1;
        w_nxt   = S_M_WAIT;
      end
      S_M_WAIT: begin
        if ((w_is_lw && bus.rdata_valid) || (w_is_sw && bus.write_done)) w_nxt = S_WB;
        else if (r_cnt == BUS_TIMEOUT) w_nxt = S_TRAP;
      end
      S_WB: begin
        w_reg_wen = !w_is_sw && w_rd_nz;
        w_pc_en   = 1'b1;
        w_nxt     = RUN ? S_F_REQ : S_IDLE;
      end
      default: w_nxt = r_state;  // S_TRAP: held until reset
    endcase
    // Decoded selects stay stable from EXE through WB
    if (w_span) begin
      w_alu_cs   = w_is_jal ? ALU_PC : ALU_REG0;
      w_alu_mode = w_is_r & r_ir[30];
      if (w_is_jal)      w_reg_cs = REG_PC;
      else if (w_is_lui) w_reg_cs = REG_IM;
      else if (w_is_lw)  w_reg_cs = REG_LOAD;
      else               w_reg_cs = REG_ALU;
    end
    if (w_mem) begin
      w_addr_cs  = ADDR_ALU;
      w_mode_bus = w_is_sw;
      w_data_cs  = DATA_REG1;
    end
  end

  assign bus.start_transaction = w_start;
  assign bus.mode_BUS          = w_mode_bus;
  assign bus.addr_CS           = w_addr_cs;
  assign bus.data_CS           = w_data_cs;

  assign PC_EN      = w_pc_en;
  assign PC_mode    = w_pc_mode;
  assign PC_CS      = PCS_ALU;
  assign pc_init    = RESET_PC;
  assign ALU_mode   = w_alu_mode;
  assign ALU_CS     = w_alu_cs;
  assign reg_raddr1 = r_ir[19:15];
  assign reg_raddr2 = r_ir[24:20];
  assign reg_waddr  = r_ir[11:7];
  assign reg_wen    = w_reg_wen;
  assign reg_CS     = w_reg_cs;
  assign IR         = r_ir;
  assign load_data  = r_load_data;
  assign halted     = (r_state == S_IDLE);
  assign trap       = (r_state == S_TRAP);

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: ADDI, LW, SW, JAL, RUN drop, illegal op, bus timeout, reset.
module tb_cpu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RUN = 1'b0;
  logic        PC_EN, PC_mode, ALU_mode, reg_wen, halted, trap;
  logic [1:0]  PC_CS, ALU_CS;
  logic [2:0]  reg_CS;
  logic [4:0]  reg_raddr1, reg_raddr2, reg_waddr;
  logic [31:0] pc_init, IR, IM, load_data;

  int n_vec = 0;
  int n_bad = 0;

  cpu_ctrl_seq_if bus();

  cpu_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .RUN(RUN), .bus(bus),
    .PC_EN(PC_EN), .PC_mode(PC_mode), .PC_CS(PC_CS), .pc_init(pc_init),
    .ALU_mode(ALU_mode), .ALU_CS(ALU_CS),
    .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2), .reg_waddr(reg_waddr),
    .reg_wen(reg_wen), .reg_CS(reg_CS), .IR(IR), .IM(IM), .load_data(load_data),
    .halted(halted), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the sequencer issues a bus request (bounded)
  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (bus.start_transaction) return;
      tick();
    end
    chk("req_timeout", 32'd0, 32'd1);
  endtask

  // Serve an instruction fetch with 2-cycle read latency; returns in DEC
  task automatic fetch(input logic [31:0] instr);
    wait_req();
    chk("f_addr_cs", bus.addr_CS, 32'd3);
    chk("f_mode", bus.mode_BUS, 32'd0);
    tick();
    chk("f_single_pulse", bus.start_transaction, 32'd0);
    tick();
    bus.rdata = instr;
    bus.rdata_valid = 1'b1;
    tick();
    bus.rdata_valid = 1'b0;
    chk("ir", IR, instr);
  endtask

  initial begin
    bus.rdata_valid = 1'b0;
    bus.write_done  = 1'b0;
    bus.rdata       = 32'd0;
    #12;
    // Reset state
    chk("rst_halted", halted, 32'd1);
    chk("rst_trap", trap, 32'd0);
    chk("rst_start", bus.start_transaction, 32'd0);
    chk("rst_wen", reg_wen, 32'd0);
    chk("rst_pcen", PC_EN, 32'd0);
    chk("rst_ir", IR, 32'd0);
    chk("rst_addr_cs", bus.addr_CS, 32'd0);
    chk("pc_init", pc_init, 32'd0);
    rst_n = 1'b1;
    tick();
    RUN = 1'b1;
    tick();

    // ADDI x1,x0,5
    fetch(32'h00500093);
    chk("addi_im", IM, 32'd5);
    chk("addi_rd", reg_waddr, 32'd1);
    tick();
    chk("addi_alu_cs", ALU_CS, 32'd2);
    chk("addi_reg_cs", reg_CS, 32'd0);
    chk("addi_exe_wen", reg_wen, 32'd0);
    tick();
    chk("addi_wb_wen", reg_wen, 32'd1);
    chk("addi_wb_pcen", PC_EN, 32'd1);
    chk("addi_wb_pcmode", PC_mode, 32'd0);
    tick();
    chk("addi_wen_once", reg_wen, 32'd0);
    chk("addi_pcen_once", PC_EN, 32'd0);

    // LW x2,8(x1)
    fetch(32'h0080A103);
    chk("lw_im", IM, 32'd8);
    chk("lw_rs1", reg_raddr1, 32'd1);
    tick();
    chk("lw_exe_alu_cs", ALU_CS, 32'd2);
    tick();
    chk("lw_req", bus.start_transaction, 32'd1);
    chk("lw_mode", bus.mode_BUS, 32'd0);
    chk("lw_addr_cs", bus.addr_CS, 32'd0);
    tick();
    tick();
    bus.rdata = 32'hDEADBEEF;
    bus.rdata_valid = 1'b1;
    tick();
    bus.rdata_valid = 1'b0;
    chk("lw_data", load_data, 32'hDEADBEEF);
    chk("lw_reg_cs", reg_CS, 32'd5);
    chk("lw_wen", reg_wen, 32'd1);
    chk("lw_rd", reg_waddr, 32'd2);
    tick();

    // SW x2,4(x1)
    fetch(32'h0020A223);
    chk("sw_im", IM, 32'd4);
    chk("sw_rs2", reg_raddr2, 32'd2);
    tick();
    tick();
    chk("sw_req", bus.start_transaction, 32'd1);
    chk("sw_mode", bus.mode_BUS, 32'd1);
    chk("sw_data_cs", bus.data_CS, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sw_wait_pcen", PC_EN, 32'd0);
    end
    bus.write_done = 1'b1;
    tick();
    bus.write_done = 1'b0;
    chk("sw_wb_pcen", PC_EN, 32'd1);
    chk("sw_no_wen", reg_wen, 32'd0);
    tick();

    // JAL x1,+16
    fetch(32'h010000EF);
    chk("jal_im", IM, 32'd16);
    tick();
    chk("jal_pcmode", PC_mode, 32'd1);
    chk("jal_pc_cs", PC_CS, 32'd0);
    chk("jal_alu_cs", ALU_CS, 32'd0);
    chk("jal_reg_cs", reg_CS, 32'd3);
    chk("jal_wen", reg_wen, 32'd1);
    chk("jal_pcen", PC_EN, 32'd1);
    tick();
    chk("jal_next_fetch", bus.start_transaction, 32'd1);

    // RUN dropped during EXE of ADDI
    fetch(32'h00500093);
    tick();
    RUN = 1'b0;
    tick();
    chk("rdrop_wb_wen", reg_wen, 32'd1);
    tick();
    chk("rdrop_halted", halted, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rdrop_no_fetch", bus.start_transaction, 32'd0);
    end

    // Illegal opcode
    RUN = 1'b1;
    fetch(32'h0000007F);
    tick();
    chk("ill_trap", trap, 32'd1);
    chk("ill_halted", halted, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ill_no_fetch", bus.start_transaction, 32'd0);
    end
    rst_n = 1'b0;
    #1;
    chk("ill_rst_trap", trap, 32'd0);
    chk("ill_rst_halted", halted, 32'd1);
    tick();
    rst_n = 1'b1;

    // Fetch that never completes -> bus timeout trap
    wait_req();
    begin
      int cyc;
      cyc = 0;
      while (!trap && cyc < 400) begin
        tick();
        cyc++;
      end
      chk("tmo_trap", trap, 32'd1);
      chk("tmo_not_early", 32'(cyc >= 255), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_stays", trap, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("tmo_rst_trap", trap, 32'd0);
    chk("tmo_rst_halted", halted, 32'd1);
    tick();
    rst_n = 1'b1;

    // Async reset in the middle of a fetch
    wait_req();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_halted", halted, 32'd1);
    chk("mid_rst_start", bus.start_transaction, 32'd0);
    tick();
    chk("mid_rst_ir", IR, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
